// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 restoring divider family.
//   div_state_e : divider FSM states
//   MAX_WIDTH   : widest operand any divider in the family supports
//   CNT_W       : iteration counter width, sized for MAX_WIDTH
//   abs_mag()   : operand magnitude, two's-complement aware
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FIX    = 2'd2,
        FINISH = 2'd3
    } div_state_e;

    localparam int MAX_WIDTH = 32;
    localparam int CNT_W     = $clog2(MAX_WIDTH + 1);

    // Magnitude of an operand held zero-extended in MAX_WIDTH bits; msb is the
    // operand's sign bit position. The caller truncates back to its own width,
    // so |MIN| comes out as 2^(WIDTH-1), which is representable unsigned.
    function automatic logic [MAX_WIDTH-1:0] abs_mag(
        input logic [MAX_WIDTH-1:0] value,
        input logic [4:0]           msb,
        input logic                 signed_op
    );
        logic [MAX_WIDTH-1:0] mag;
        if (signed_op && value[msb]) begin
            mag = {MAX_WIDTH{1'b0}} - value;
        end else begin
            mag = value;
        end
        return mag;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring-division step (purely combinational).
//   R_in  : partial remainder (always < D)
//   Q_in  : dividend bits still to shift in (MSB first) / quotient bits so far
//   D     : divisor magnitude
//   R_out : updated partial remainder
//   Q_out : Q_in shifted left with the new quotient bit in the LSB
module div_restore_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] R_in,
    input  logic [WIDTH-1:0] Q_in,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R_out,
    output logic [WIDTH-1:0] Q_out
);

    // Shifted remainder can reach WIDTH+1 bits with an unsigned full-range
    // divisor, so the trial subtract carries one more bit as the borrow.
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] trial_s;
    logic             fits_s;

    assign shifted_s = {R_in, Q_in[WIDTH-1]};
    assign trial_s   = {1'b0, shifted_s} - {2'b00, D};
    assign fits_s    = ~trial_s[WIDTH+1];

    // Keep the difference when the divisor fits, otherwise restore.
    always_comb begin
        R_out = WIDTH'(shifted_s);
        if (fits_s) begin
            R_out = WIDTH'(trial_s);
        end else begin
            R_out = WIDTH'(shifted_s);
        end
        Q_out = {Q_in[WIDTH-2:0], fits_s};
    end

endmodule

// File: rtl/seq_divider_param.sv
// Multi-cycle WIDTH-bit restoring divider, one quotient bit per clock,
// signed or unsigned per operation, truncating semantics.
//   clk, rst            : clock, synchronous active-high reset
//   start, signed_op    : request and mode, sampled when busy=0
//   A, B                : dividend / divisor, sampled with start
//   quotient, remainder : registered results, held until overwritten
//   busy, done          : operation in progress / one-cycle completion pulse
//   div_zero, overflow  : B==0 / signed MIN/-1 for the completed operation
module seq_divider_param
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             overflow
);

    localparam logic [4:0]       MSB_POS = 5'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

    div_state_e       state_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] a_r;
    logic             q_sign_r;
    logic             r_sign_r;
    logic             zero_r;
    logic             ovf_r;

    logic             accept_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic             b_zero_s;
    logic             ovf_s;
    logic [WIDTH-1:0] r_next_s;
    logic [WIDTH-1:0] q_next_s;

    // busy is low in both IDLE and FINISH, so a start in the done cycle is
    // accepted straight away.
    assign accept_s = start & ~busy;
    assign a_mag_s  = WIDTH'(abs_mag(MAX_WIDTH'(A), MSB_POS, signed_op));
    assign b_mag_s  = WIDTH'(abs_mag(MAX_WIDTH'(B), MSB_POS, signed_op));
    assign b_zero_s = (B == ZERO);
    assign ovf_s    = signed_op & (A == MIN_VAL) & (B == ONES);

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .R_in  (r_r),
        .Q_in  (q_r),
        .D     (d_r),
        .R_out (r_next_s),
        .Q_out (q_next_s)
    );

    // Divider FSM: operand capture, bit iteration, sign fix-up and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            count_r   <= {CNT_W{1'b0}};
            r_r       <= ZERO;
            q_r       <= ZERO;
            d_r       <= ZERO;
            a_r       <= ZERO;
            q_sign_r  <= 1'b0;
            r_sign_r  <= 1'b0;
            zero_r    <= 1'b0;
            ovf_r     <= 1'b0;
            quotient  <= ZERO;
            remainder <= ZERO;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept_s) begin
            q_sign_r <= (A[WIDTH-1] ^ B[WIDTH-1]) & signed_op;
            r_sign_r <= A[WIDTH-1] & signed_op;
            // q_r starts as |A| and is shifted out MSB first while quotient
            // bits shift in from the bottom.
            q_r      <= a_mag_s;
            d_r      <= b_mag_s;
            r_r      <= ZERO;
            a_r      <= A;
            zero_r   <= b_zero_s;
            ovf_r    <= ovf_s;
            count_r  <= CNT_W'(WIDTH);
            busy     <= 1'b1;
            done     <= 1'b0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
            if (b_zero_s) begin
                state_r <= FIX;
            end else begin
                state_r <= CALC;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                CALC: begin
                    r_r     <= r_next_s;
                    q_r     <= q_next_s;
                    count_r <= count_r - CNT_W'(1);
                    if (count_r == CNT_W'(1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    if (zero_r) begin
                        quotient  <= ONES;
                        remainder <= a_r;
                    end else begin
                        quotient  <= q_sign_r ? (ZERO - q_r) : q_r;
                        remainder <= r_sign_r ? (ZERO - r_r) : r_r;
                    end
                    div_zero <= zero_r;
                    overflow <= ovf_r;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_r  <= FINISH;
                end
                FINISH: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_param.sv
module tb_seq_divider_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // WIDTH=8 instance
    logic       start8, sop8, busy8, done8, dz8, ov8;
    logic [7:0] a8, b8, q8, r8;
    // WIDTH=16 instance
    logic        start16, sop16, busy16, done16, dz16, ov16;
    logic [15:0] a16, b16, q16, r16;
    // WIDTH=5 instance
    logic       start5, sop5, busy5, done5, dz5, ov5;
    logic [4:0] a5, b5, q5, r5;

    seq_divider_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_op(sop8), .A(a8), .B(b8),
        .quotient(q8), .remainder(r8), .busy(busy8), .done(done8),
        .div_zero(dz8), .overflow(ov8)
    );

    seq_divider_param #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_op(sop16), .A(a16), .B(b16),
        .quotient(q16), .remainder(r16), .busy(busy16), .done(done16),
        .div_zero(dz16), .overflow(ov16)
    );

    seq_divider_param #(.WIDTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .start(start5), .signed_op(sop5), .A(a5), .B(b5),
        .quotient(q5), .remainder(r5), .busy(busy5), .done(done5),
        .div_zero(dz5), .overflow(ov5)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation on the 8-bit DUT; latency counted from the start cycle.
    // With glitch=1 a stray start with new operands is pulsed while busy.
    task automatic run8(input string tag, input logic sop, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_q, input logic [7:0] exp_r, input logic exp_dz,
                        input logic exp_ov, input int exp_lat, input bit glitch);
        int cycles;
        int busy_gaps;
        bit seen;
        @(negedge clk);
        start8 = 1'b1; sop8 = sop; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; sop8 = ~sop; a8 = 8'h5A; b8 = 8'h00;
        cycles = 0; seen = 1'b0; busy_gaps = 0;
        if (!busy8) busy_gaps++;
        while (!seen && cycles < 40) begin
            if (glitch && cycles == 3) begin
                start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
            if (done8) seen = 1'b1;
            else if (!busy8) busy_gaps++;
        end
        start8 = 1'b0;
        check_val($sformatf("%s.latency", tag), 32'(cycles + 1), 32'(exp_lat));
        check_val($sformatf("%s.busy_gaps", tag), 32'(busy_gaps), 32'd0);
        check_val($sformatf("%s.busy_at_done", tag), {31'd0, busy8}, 32'd0);
        check_val($sformatf("%s.q", tag), {24'd0, q8}, {24'd0, exp_q});
        check_val($sformatf("%s.r", tag), {24'd0, r8}, {24'd0, exp_r});
        check_val($sformatf("%s.div_zero", tag), {31'd0, dz8}, {31'd0, exp_dz});
        check_val($sformatf("%s.overflow", tag), {31'd0, ov8}, {31'd0, exp_ov});
    endtask

    task automatic run16(input string tag, input logic sop, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_q, input logic [15:0] exp_r, input logic exp_ov,
                         input int exp_lat);
        int cycles;
        @(negedge clk);
        start16 = 1'b1; sop16 = sop; a16 = a; b16 = b;
        @(posedge clk); #1;
        start16 = 1'b0;
        cycles = 0;
        while (!done16 && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_val($sformatf("%s.latency", tag), 32'(cycles + 1), 32'(exp_lat));
        check_val($sformatf("%s.q", tag), {16'd0, q16}, {16'd0, exp_q});
        check_val($sformatf("%s.r", tag), {16'd0, r16}, {16'd0, exp_r});
        check_val($sformatf("%s.overflow", tag), {31'd0, ov16}, {31'd0, exp_ov});
    endtask

    initial begin
        int done_cnt;
        int cycles;
        logic [15:0] ra, rb;
        logic        rs;
        int          eq, er;
        logic [15:0] eq16, er16;
        logic        eov;

        rst = 1'b1;
        start8 = 1'b0; sop8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start16 = 1'b0; sop16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
        start5 = 1'b0; sop5 = 1'b0; a5 = 5'h00; b5 = 5'h00;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset.q", {24'd0, q8}, 32'd0);
        check_val("reset.r", {24'd0, r8}, 32'd0);
        check_val("reset.busy", {31'd0, busy8}, 32'd0);
        check_val("reset.done", {31'd0, done8}, 32'd0);
        check_val("reset.div_zero", {31'd0, dz8}, 32'd0);
        check_val("reset.overflow", {31'd0, ov8}, 32'd0);
        rst = 1'b0;

        // Signed basics; consecutive calls start during the done cycle (back-to-back).
        run8("s13_3",   1'b1, 8'd13,  8'd3,  8'h04, 8'h01, 1'b0, 1'b0, 10, 1'b0);
        run8("s20_m4",  1'b1, 8'd20,  8'hFC, 8'hFB, 8'h00, 1'b0, 1'b0, 10, 1'b0);
        run8("sm18_3",  1'b1, 8'hEE,  8'd3,  8'hFA, 8'h00, 1'b0, 1'b0, 10, 1'b0);
        run8("sm21_m7", 1'b1, 8'hEB,  8'hF9, 8'h03, 8'h00, 1'b0, 1'b0, 10, 1'b0);
        // Remainder takes the dividend's sign.
        run8("sm7_2",   1'b1, 8'hF9,  8'd2,  8'hFD, 8'hFF, 1'b0, 1'b0, 10, 1'b0);
        run8("s7_m2",   1'b1, 8'd7,   8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 10, 1'b0);
        run8("s5_9",    1'b1, 8'd5,   8'd9,  8'h00, 8'h05, 1'b0, 1'b0, 10, 1'b0);
        run8("s0_6",    1'b1, 8'd0,   8'd6,  8'h00, 8'h00, 1'b0, 1'b0, 10, 1'b0);
        // Unsigned: raw operands, no sign fix-up.
        run8("u200_7",  1'b0, 8'd200, 8'd7,  8'h1C, 8'h04, 1'b0, 1'b0, 10, 1'b0);
        run8("u249_2",  1'b0, 8'hF9,  8'd2,  8'h7C, 8'h01, 1'b0, 1'b0, 10, 1'b0);
        // Divide by zero and edge cases.
        run8("sm5_0",   1'b1, 8'hFB,  8'h00, 8'hFF, 8'hFB, 1'b1, 1'b0, 2,  1'b0);
        run8("u200_0",  1'b0, 8'd200, 8'h00, 8'hFF, 8'hC8, 1'b1, 1'b0, 2,  1'b0);
        run8("sm128_m1",1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 10, 1'b0);
        run8("u128_255",1'b0, 8'h80,  8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 10, 1'b0);
        // Start while busy is ignored.
        run8("ignore",  1'b1, 8'd100, 8'd10, 8'h0A, 8'h00, 1'b0, 1'b0, 10, 1'b1);
        @(posedge clk); #1;
        check_val("ignore.done_drops", {31'd0, done8}, 32'd0);
        check_val("ignore.q_held", {24'd0, q8}, 32'h0A);

        // Reset in the middle of CALC.
        @(negedge clk);
        start8 = 1'b1; sop8 = 1'b1; a8 = 8'd13; b8 = 8'd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midrst.busy", {31'd0, busy8}, 32'd0);
        check_val("midrst.done", {31'd0, done8}, 32'd0);
        check_val("midrst.q", {24'd0, q8}, 32'd0);
        check_val("midrst.r", {24'd0, r8}, 32'd0);
        done_cnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done8) done_cnt++;
        end
        check_val("midrst.no_done", 32'(done_cnt), 32'd0);

        // 16-bit build.
        run16("w16_m32768_3", 1'b1, 16'h8000, 16'd3, 16'hD556, 16'hFFFE, 1'b0, 18);
        run16("w16_ovf", 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1, 18);
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (rb == 16'd0) rb = 16'd1;
            rs = i[0];
            if (rs) begin
                eq = int'($signed(ra)) / int'($signed(rb));
                er = int'($signed(ra)) % int'($signed(rb));
                eov = (ra == 16'h8000) && (rb == 16'hFFFF);
            end else begin
                eq = int'(ra) / int'(rb);
                er = int'(ra) % int'(rb);
                eov = 1'b0;
            end
            eq16 = eq[15:0];
            er16 = er[15:0];
            run16($sformatf("w16_rand%0d", i), rs, ra, rb, eq16, er16, eov, 18);
        end

        // 5-bit build: -16 / -1 wraps and flags overflow.
        @(negedge clk);
        start5 = 1'b1; sop5 = 1'b1; a5 = 5'h10; b5 = 5'h1F;
        @(posedge clk); #1;
        start5 = 1'b0;
        cycles = 0;
        while (!done5 && cycles < 30) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_val("w5.latency", 32'(cycles + 1), 32'd7);
        check_val("w5.q", {27'd0, q5}, 32'h10);
        check_val("w5.r", {27'd0, r5}, 32'h00);
        check_val("w5.overflow", {31'd0, ov5}, 32'd1);
        check_val("w5.div_zero", {31'd0, dz5}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
